instruction_fetch_controller: RTL

- Sequences the InstructionMemory: generates the fetch PC, drives the memory's `ce` and `address`, and tracks its one-cycle read latency.
- Buffers returned instructions in a 2-entry FIFO and hands them to decode over a valid/ready handshake.
- Handles back-pressure from decode and branch redirects from execute.
- Sits between the InstructionMemory and the decode stage.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/instruction_fetch_controller.sv | 99 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch controller
package fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  localparam int FETCH_FIFO_DEPTH = 2;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - 2-entry synchronous FIFO of {pc, instr}; flush beats push and pop
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ADDRESS_WIDTH-1:0] push_pc,
  input  logic [DATA_WIDTH-1:0]    push_instr,
  input  logic                     pop,
  input  logic                     flush,
  output logic [1:0]               count,
  output logic [ADDRESS_WIDTH-1:0] head_pc,
  output logic [DATA_WIDTH-1:0]    head_instr
);

  logic [ADDRESS_WIDTH-1:0] pc_mem    [FETCH_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    instr_mem [FETCH_FIFO_DEPTH];
  logic                     rd_ptr;
  logic                     wr_ptr;

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  // Pointer/count bookkeeping; storage is zeroed on reset so the head reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < FETCH_FIFO_DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= push_pc;
        instr_mem[wr_ptr] <= push_instr;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_controller.sv
// rtl/instruction_fetch_controller.sv - fetch PC sequencing, 1-cycle memory tracking, 2-entry buffer to decode; optional FETCH_PERF_CNT_EN counters
module instruction_fetch_controller
  import fetch_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 10,
  parameter int                     DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en,
  output logic                     im_ce,
  output logic [ADDRESS_WIDTH-1:0] im_address,
  input  logic [DATA_WIDTH-1:0]    im_data,
  input  logic                     im_data_valid,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]              perf_issued,
  output logic [31:0]              perf_stall
`endif
);

  fetch_state_t             state;
  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  logic                     inflight;
  logic [ADDRESS_WIDTH-1:0] inflight_pc;
  logic [1:0]               count;
  logic                     pop;
  logic                     push;
  logic [2:0]               occupancy;

  assign out_valid  = (count != 2'd0);
  assign pop        = out_valid & out_ready;
  assign push       = inflight & im_data_valid & ~redirect_valid;
  assign im_address = fetch_pc;

  // Buffered plus in-flight entries; a same-cycle pop frees one slot for a new read.
  assign occupancy  = {1'b0, count} + {2'b00, inflight};
  assign im_ce      = (state == RUN) & ~redirect_valid &
                      (occupancy < (3'd2 + {2'b00, pop}));

  fetch_fifo #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_pc    (inflight_pc),
    .push_instr (im_data),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (count),
    .head_pc    (out_pc),
    .head_instr (out_instr)
  );

  // FSM and PC sequencing; a redirect retargets the PC and cancels the in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      state <= fetch_en ? RUN : IDLE;
      if (im_ce) begin
        fetch_pc    <= fetch_pc + 1'b1;
        inflight    <= 1'b1;
        inflight_pc <= fetch_pc;
      end else begin
        inflight <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Free-running event counters, wrapping on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued <= 32'd0;
      perf_stall  <= 32'd0;
    end else begin
      perf_issued <= perf_issued + {31'd0, im_ce};
      perf_stall  <= perf_stall + {31'd0, out_valid & ~out_ready};
    end
  end
`endif

endmodule
